// File: rtl/sccb_config_sequencer.sv
// rtl/sccb_config_sequencer.sv - table-driven SCCB/I2C register write sequencer
// Walks {reg,value} table entries with END/DELAY markers, retries NACKed writes.
module sccb_config_sequencer #(
    parameter int                           ADDR_W       = 8,
    parameter int                           REG_W        = 8,
    parameter int                           VAL_W        = 8,
    parameter logic [REG_W+VAL_W-1:0]       END_MARK     = 16'hFFFF,
    parameter logic [REG_W+VAL_W-1:0]       DELAY_MARK   = 16'hFFF0,
    parameter int                           DELAY_CYCLES = 1000000,
    parameter int                           MAX_RETRY    = 3
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    start_i,
    output logic [ADDR_W-1:0]       rom_addr_o,
    input  logic [REG_W+VAL_W-1:0]  rom_data_i,
    output logic                    wr_valid_o,
    input  logic                    wr_ready_i,
    output logic [REG_W-1:0]        wr_reg_o,
    output logic [VAL_W-1:0]        wr_val_o,
    input  logic                    wr_done_i,
    input  logic                    wr_nack_i,
    output logic                    busy_o,
    output logic                    done_o,
    output logic                    error_o,
    output logic [1:0]              err_code_o,
    output logic [ADDR_W:0]         wr_count_o
);

    localparam int DW    = REG_W + VAL_W;
    localparam int CNT_W = $clog2(DELAY_CYCLES + 1);
    localparam int RTY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

    localparam logic [CNT_W-1:0]  DELAY_LOAD = CNT_W'(DELAY_CYCLES - 1);
    localparam logic [RTY_W-1:0]  RETRY_MAX  = RTY_W'(MAX_RETRY);
    localparam logic [ADDR_W-1:0] LAST_ADDR  = '1;

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_DECODE, S_ISSUE, S_WAIT_RESP, S_DELAY, S_FINISH, S_FAIL
    } state_t;

    state_t              state_q;
    logic [ADDR_W-1:0]   rom_addr_q;
    logic                wr_valid_q;
    logic [REG_W-1:0]    wr_reg_q;
    logic [VAL_W-1:0]    wr_val_q;
    logic                busy_q;
    logic                done_q;
    logic                error_q;
    logic [1:0]          err_code_q;
    logic [ADDR_W:0]     wr_count_q;
    logic [CNT_W-1:0]    delay_cnt_q;
    logic [RTY_W-1:0]    retry_q;
    logic                advance;

    // An entry is complete after an ACKed write or an expired delay.
    assign advance = ((state_q == S_WAIT_RESP) && wr_done_i && !wr_nack_i) ||
                     ((state_q == S_DELAY) && (delay_cnt_q == '0));

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= S_IDLE;
            rom_addr_q  <= '0;
            wr_valid_q  <= 1'b0;
            wr_reg_q    <= '0;
            wr_val_q    <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
            err_code_q  <= 2'd0;
            wr_count_q  <= '0;
            delay_cnt_q <= '0;
            retry_q     <= '0;
        end else begin
            case (state_q)
                S_IDLE, S_FINISH, S_FAIL: begin
                    if (start_i) begin
                        done_q     <= 1'b0;
                        error_q    <= 1'b0;
                        err_code_q <= 2'd0;
                        wr_count_q <= '0;
                        rom_addr_q <= '0;
                        busy_q     <= 1'b1;
                        state_q    <= S_FETCH;
                    end
                end
                S_FETCH: state_q <= S_DECODE;
                S_DECODE: begin
                    if (rom_data_i == END_MARK) begin
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= S_FINISH;
                    end else if (rom_data_i == DELAY_MARK) begin
                        delay_cnt_q <= DELAY_LOAD;
                        state_q     <= S_DELAY;
                    end else begin
                        wr_reg_q   <= rom_data_i[DW-1 -: REG_W];
                        wr_val_q   <= rom_data_i[VAL_W-1:0];
                        retry_q    <= '0;
                        wr_valid_q <= 1'b1;
                        state_q    <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (wr_ready_i) begin
                        wr_valid_q <= 1'b0;
                        state_q    <= S_WAIT_RESP;
                    end
                end
                S_WAIT_RESP: begin
                    if (wr_done_i) begin
                        if (!wr_nack_i) begin
                            wr_count_q <= wr_count_q + (ADDR_W+1)'(1);
                        end else if (retry_q != RETRY_MAX) begin
                            retry_q    <= retry_q + RTY_W'(1);
                            wr_valid_q <= 1'b1;
                            state_q    <= S_ISSUE;
                        end else begin
                            busy_q     <= 1'b0;
                            done_q     <= 1'b0;
                            error_q    <= 1'b1;
                            err_code_q <= 2'd1;
                            state_q    <= S_FAIL;
                        end
                    end
                end
                S_DELAY: begin
                    if (delay_cnt_q != '0) begin
                        delay_cnt_q <= delay_cnt_q - CNT_W'(1);
                    end
                end
                default: state_q <= S_IDLE;
            endcase

            // Running off the last table slot without END_MARK is an overrun.
            if (advance) begin
                if (rom_addr_q == LAST_ADDR) begin
                    busy_q     <= 1'b0;
                    done_q     <= 1'b1;
                    error_q    <= 1'b1;
                    err_code_q <= 2'd2;
                    state_q    <= S_FINISH;
                end else begin
                    rom_addr_q <= rom_addr_q + ADDR_W'(1);
                    state_q    <= S_FETCH;
                end
            end
        end
    end

    assign rom_addr_o = rom_addr_q;
    assign wr_valid_o = wr_valid_q;
    assign wr_reg_o   = wr_reg_q;
    assign wr_val_o   = wr_val_q;
    assign busy_o     = busy_q;
    assign done_o     = done_q;
    assign error_o    = error_q;
    assign err_code_o = err_code_q;
    assign wr_count_o = wr_count_q;

endmodule

// File: tb/tb_sccb_config_sequencer.sv
// tb/tb_sccb_config_sequencer.sv - self-checking bench for sccb_config_sequencer
// Directed vector table, hand sequences and randomized tables against a table-walk model.
module tb_sccb_config_sequencer;

    localparam int DLY = 16;
    localparam int MR  = 3;
    localparam logic [15:0] ENDM = 16'hFFFF;
    localparam logic [15:0] DLYM = 16'hFFF0;

    logic        clk;
    logic        rst_i, start_i;
    logic [1:0]  rom_addr_o;
    logic [15:0] rom_data_i;
    logic        wr_valid_o, wr_ready_i;
    logic [7:0]  wr_reg_o, wr_val_o;
    logic        wr_done_i, wr_nack_i;
    logic        busy_o, done_o, error_o;
    logic [1:0]  err_code_o;
    logic [2:0]  wr_count_o;

    sccb_config_sequencer #(
        .ADDR_W(2), .REG_W(8), .VAL_W(8), .END_MARK(ENDM), .DELAY_MARK(DLYM),
        .DELAY_CYCLES(DLY), .MAX_RETRY(MR)
    ) dut (
        .clk_i(clk), .rst_i(rst_i), .start_i(start_i),
        .rom_addr_o(rom_addr_o), .rom_data_i(rom_data_i),
        .wr_valid_o(wr_valid_o), .wr_ready_i(wr_ready_i),
        .wr_reg_o(wr_reg_o), .wr_val_o(wr_val_o),
        .wr_done_i(wr_done_i), .wr_nack_i(wr_nack_i),
        .busy_o(busy_o), .done_o(done_o), .error_o(error_o),
        .err_code_o(err_code_o), .wr_count_o(wr_count_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    logic [15:0] rom [4];
    always @(posedge clk) rom_data_i <= rom[rom_addr_o];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int failures = 0;

    // Responder state shared with the test flow
    int stall_cfg = 0, lat_cfg = 3, rand_mode = 0;
    int stall_bad, drop_bad, start_cyc;
    logic [7:0] hold_reg, hold_val;
    bit nack_q[$];
    bit plan[$];
    logic [7:0] obs_reg[$], obs_val[$];
    int valid_cyc[$], done_cyc[$];

    // Model results
    logic [7:0] exp_reg[$], exp_val[$];
    int m_cnt, m_done, m_err, m_code, m_addr;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    initial begin : responder
        int stall, lat;
        bit nk;
        wr_ready_i = 1'b0;
        wr_done_i  = 1'b0;
        wr_nack_i  = 1'b0;
        forever begin
            @(negedge clk);
            if (wr_valid_o && !rst_i) begin
                valid_cyc.push_back(cyc);
                stall = (rand_mode != 0) ? int'($urandom_range(0, 3)) : stall_cfg;
                lat   = (rand_mode != 0) ? int'($urandom_range(1, 4)) : lat_cfg;
                hold_reg = wr_reg_o;
                hold_val = wr_val_o;
                for (int s = 0; s < stall; s++) begin
                    @(negedge clk);
                    if (!wr_valid_o || wr_reg_o != hold_reg || wr_val_o != hold_val) stall_bad++;
                end
                obs_reg.push_back(wr_reg_o);
                obs_val.push_back(wr_val_o);
                wr_ready_i = 1'b1;
                @(negedge clk);
                wr_ready_i = 1'b0;
                if (wr_valid_o) drop_bad++;
                nk = (nack_q.size() > 0) ? nack_q.pop_front() : 1'b0;
                for (int l = 1; l < lat; l++) @(negedge clk);
                wr_done_i = 1'b1;
                wr_nack_i = nk;
                done_cyc.push_back(cyc);
                @(negedge clk);
                wr_done_i = 1'b0;
                wr_nack_i = 1'b0;
            end
        end
    end

    function automatic logic [3:0][15:0] mk4(input logic [15:0] a, b, c, d);
        logic [3:0][15:0] r;
        r[0] = a; r[1] = b; r[2] = c; r[3] = d;
        return r;
    endfunction

    // Walk the table entry by entry, consuming the planned NACK answers.
    task automatic model(input logic [3:0][15:0] t);
        int ti;
        bit ok, nk;
        exp_reg.delete();
        exp_val.delete();
        m_cnt = 0; m_done = 0; m_err = 0; m_code = 0; m_addr = 0;
        ti = 0;
        for (int a = 0; a < 4; a++) begin
            m_addr = a;
            if (t[a] == ENDM) begin
                m_done = 1;
                return;
            end
            if (t[a] == DLYM) continue;
            ok = 1'b0;
            for (int k = 0; k <= MR && !ok; k++) begin
                exp_reg.push_back(t[a][15:8]);
                exp_val.push_back(t[a][7:0]);
                nk = (ti < plan.size()) ? plan[ti] : 1'b0;
                ti++;
                if (!nk) begin
                    ok = 1'b1;
                    m_cnt++;
                end
            end
            if (!ok) begin
                m_err = 1;
                m_code = 1;
                return;
            end
        end
        m_done = 1; m_err = 1; m_code = 2;
    endtask

    task automatic run_seq(input logic [3:0][15:0] t, input int poke);
        int n;
        for (int i = 0; i < 4; i++) rom[i] = t[i];
        nack_q = plan;
        obs_reg.delete(); obs_val.delete(); valid_cyc.delete(); done_cyc.delete();
        stall_bad = 0;
        drop_bad = 0;
        @(negedge clk);
        start_i = 1'b1;
        start_cyc = cyc;
        @(negedge clk);
        start_i = 1'b0;
        chk("start_busy", int'(busy_o), 1);
        chk("start_clears", int'({done_o, error_o, err_code_o, wr_count_o}), 0);
        n = 0;
        while (busy_o && n < 3000) begin
            start_i = (poke > 0 && n == poke);
            @(negedge clk);
            n++;
        end
        start_i = 1'b0;
        chk("seq_terminates", int'(busy_o), 0);
        repeat (3) @(negedge clk);
    endtask

    task automatic check_result(input logic [3:0][15:0] t);
        int nmin;
        model(t);
        chk("n_writes", obs_reg.size(), exp_reg.size());
        nmin = (obs_reg.size() < exp_reg.size()) ? obs_reg.size() : exp_reg.size();
        for (int i = 0; i < nmin; i++) begin
            chk("wr_reg", int'(obs_reg[i]), int'(exp_reg[i]));
            chk("wr_val", int'(obs_val[i]), int'(exp_val[i]));
        end
        chk("wr_count", int'(wr_count_o), m_cnt);
        chk("done", int'(done_o), m_done);
        chk("error", int'(error_o), m_err);
        chk("err_code", int'(err_code_o), m_code);
        chk("rom_addr", int'(rom_addr_o), m_addr);
        chk("end_wr_valid", int'(wr_valid_o), 0);
        chk("stall_stable", stall_bad, 0);
        chk("valid_drop", drop_bad, 0);
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_rom_addr"}, int'(rom_addr_o), 0);
        chk({tag, "_wr_valid"}, int'(wr_valid_o), 0);
        chk({tag, "_wr_reg_val"}, int'({wr_reg_o, wr_val_o}), 0);
        chk({tag, "_busy"}, int'(busy_o), 0);
        chk({tag, "_done"}, int'(done_o), 0);
        chk({tag, "_error"}, int'(error_o), 0);
        chk({tag, "_err_code"}, int'(err_code_o), 0);
        chk({tag, "_wr_count"}, int'(wr_count_o), 0);
    endtask

    typedef struct packed {
        logic [3:0][15:0] tbl;
        logic [7:0]       nacks;
        logic [3:0]       stall;
        logic [3:0]       n_wr;
        logic [2:0]       cnt;
        logic             done;
        logic             err;
        logic [1:0]       code;
        logic [1:0]       addr;
    } vec_t;

    vec_t vecs [7];

    initial begin : main
        logic [3:0][15:0] t1, rt;
        logic [15:0] e;
        int n, r;

        t1 = mk4(16'h1280, DLYM, 16'h1204, ENDM);
        vecs[0] = '{tbl: t1, nacks: 8'h00, stall: 4'd0, n_wr: 4'd2, cnt: 3'd2, done: 1'b1, err: 1'b0, code: 2'd0, addr: 2'd3};
        vecs[1] = '{tbl: t1, nacks: 8'h00, stall: 4'd5, n_wr: 4'd2, cnt: 3'd2, done: 1'b1, err: 1'b0, code: 2'd0, addr: 2'd3};
        vecs[2] = '{tbl: t1, nacks: 8'h03, stall: 4'd0, n_wr: 4'd4, cnt: 3'd2, done: 1'b1, err: 1'b0, code: 2'd0, addr: 2'd3};
        vecs[3] = '{tbl: t1, nacks: 8'hFF, stall: 4'd1, n_wr: 4'd4, cnt: 3'd0, done: 1'b0, err: 1'b1, code: 2'd1, addr: 2'd0};
        vecs[4] = '{tbl: mk4(16'h0102, 16'h0304, 16'h0506, 16'h0708), nacks: 8'h00, stall: 4'd0,
                    n_wr: 4'd4, cnt: 3'd4, done: 1'b1, err: 1'b1, code: 2'd2, addr: 2'd3};
        vecs[5] = '{tbl: mk4(ENDM, 16'h1111, 16'h2222, 16'h3333), nacks: 8'h00, stall: 4'd0,
                    n_wr: 4'd0, cnt: 3'd0, done: 1'b1, err: 1'b0, code: 2'd0, addr: 2'd0};
        vecs[6] = '{tbl: mk4(16'h0A0B, 16'h0C0D, ENDM, 16'h0000), nacks: 8'h1E, stall: 4'd2,
                    n_wr: 4'd5, cnt: 3'd1, done: 1'b0, err: 1'b1, code: 2'd1, addr: 2'd1};

        for (int i = 0; i < 4; i++) rom[i] = 16'h0000;
        start_i = 1'b0;
        rst_i = 1'b1;
        repeat (3) @(negedge clk);
        check_reset("reset");
        rst_i = 1'b0;

        for (int v = 0; v < 7; v++) begin
            stall_cfg = int'(vecs[v].stall);
            lat_cfg = 3;
            plan.delete();
            for (int b = 0; b < 8; b++) plan.push_back(vecs[v].nacks[b]);
            run_seq(vecs[v].tbl, 0);
            chk($sformatf("v%0d_n_writes", v), obs_reg.size(), int'(vecs[v].n_wr));
            chk($sformatf("v%0d_wr_count", v), int'(wr_count_o), int'(vecs[v].cnt));
            chk($sformatf("v%0d_flags", v), int'({done_o, error_o, err_code_o}),
                int'({vecs[v].done, vecs[v].err, vecs[v].code}));
            chk($sformatf("v%0d_rom_addr", v), int'(rom_addr_o), int'(vecs[v].addr));
            chk($sformatf("v%0d_busy", v), int'(busy_o), 0);
            check_result(vecs[v].tbl);
            if (valid_cyc.size() > 0)
                chk($sformatf("v%0d_first_latency", v), valid_cyc[0] - start_cyc, 3);
            if (v == 0 && valid_cyc.size() >= 2 && done_cyc.size() >= 1)
                chk("delay_gap", valid_cyc[1] - done_cyc[0], DLY + 5);
        end

        // start pulse during the delay entry must not restart the walk
        stall_cfg = 0;
        lat_cfg = 3;
        plan.delete();
        run_seq(t1, 15);
        chk("start_ignored_writes", obs_reg.size(), 2);
        check_result(t1);

        // reset while waiting in a delay entry, then a full replay
        for (int i = 0; i < 4; i++) rom[i] = t1[i];
        plan.delete();
        nack_q.delete();
        @(negedge clk);
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        n = 0;
        while (wr_count_o != 3'd1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("reach_first_write", int'(wr_count_o), 1);
        repeat (5) @(negedge clk);
        chk("in_delay_busy", int'(busy_o), 1);
        chk("in_delay_addr", int'(rom_addr_o), 1);
        rst_i = 1'b1;
        @(negedge clk);
        check_reset("rst_in_delay");
        rst_i = 1'b0;
        repeat (2) @(negedge clk);
        run_seq(t1, 0);
        check_result(t1);
        chk("replay_first_reg", (obs_reg.size() > 0) ? int'(obs_reg[0]) : -1, 8'h12);

        // randomized tables, answers and handshake timing
        rand_mode = 1;
        for (int it = 0; it < 40; it++) begin
            for (int a = 0; a < 4; a++) begin
                r = int'($urandom_range(0, 9));
                if (r < 1) e = ENDM;
                else if (r < 3) e = DLYM;
                else begin
                    e = 16'($urandom);
                    if (e == ENDM || e == DLYM) e = e ^ 16'h0100;
                end
                rt[a] = e;
            end
            plan.delete();
            for (int b = 0; b < 16; b++) plan.push_back($urandom_range(0, 9) < 3);
            run_seq(rt, 0);
            check_result(rt);
        end
        rand_mode = 0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
